// File: rtl/video_pkg.sv
// Shared definitions for the video switch sequencer: FSM state codes and mode-line bit positions.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package video_pkg;

   // FSM state encodings, also visible to the host on state_out
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SETTLE = 3'd1;
   localparam logic [2:0] ST_APPLY  = 3'd2;
   localparam logic [2:0] ST_ON     = 3'd3;
   localparam logic [2:0] ST_MUTE   = 3'd4;

   // Bit positions inside host_mode and the applied mode register
   localparam int MODE_HD_SD_BIT    = 2;
   localparam int MODE_RGB_COMP_BIT = 1;
   localparam int MODE_INT_EXT_BIT  = 0;

   // States in which the sequencer is moving between stable configurations
   function automatic logic is_busy(input logic [2:0] st);
      return (st == ST_SETTLE) || (st == ST_APPLY) || (st == ST_MUTE);
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises an asynchronous active-low strobe and emits a one-clock pulse on each 1->0 transition.
// Latency: 3 clocks from pin fall to pulse (2 synchroniser flops + registered edge).
// Backpressure: none; every detected edge is presented exactly once.
module sync_edge_detect (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async_x,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_sync_d;
   logic r_fall;

   // Two-flop synchroniser, one history flop and a registered falling-edge pulse.
   // Idle level of the strobe is high, so the chain resets high to avoid a false edge.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_meta   <= 1'b1;
         r_sync   <= 1'b1;
         r_sync_d <= 1'b1;
         r_fall   <= 1'b0;
      end else begin
         r_meta   <= i_async_x;
         r_sync   <= r_meta;
         r_sync_d <= r_sync;
         r_fall   <= r_sync_d & ~r_sync;
      end
   end

   assign o_fall = r_fall;

endmodule

// File: rtl/video_switch_sequencer.sv
// Sequences video output on/off: waits for a stable input format, applies the host mode while muted, then enables output.
// Latency: output enable follows APPLY entry by BLANK_CYCLES clocks; mute takes effect the clock after an abort condition.
// Backpressure: none; host requests are level inputs re-evaluated every clock.
module video_switch_sequencer
   import video_pkg::*;
#(
   parameter int SETTLE_FRAMES = 4,
   parameter int BLANK_CYCLES  = 50000,
   parameter int VSYNC_TIMEOUT = 2500000
) (
   input  logic       clk_50mhz_in,
   input  logic       reset_x,
   input  logic       vsync_x_in,
   input  logic [7:0] video_format,
   input  logic       host_enable,
   input  logic [2:0] host_mode,
   output logic       video_oe_x,
   output logic       hd_sd_x,
   output logic       rgb_comp_x,
   output logic       int_ext_x,
   output logic       busy,
   output logic [2:0] state_out
);

   localparam int FW = $clog2(SETTLE_FRAMES + 1);
   localparam int DW = $clog2(BLANK_CYCLES + 1);
   localparam int TW = $clog2(VSYNC_TIMEOUT + 1);

   localparam logic [FW-1:0] FRAMES_MAX = FW'(SETTLE_FRAMES);
   localparam logic [DW-1:0] DWELL_MAX  = DW'(BLANK_CYCLES);
   localparam logic [DW-1:0] DWELL_LAST = DW'(BLANK_CYCLES - 1);
   localparam logic [TW-1:0] TO_MAX     = TW'(VSYNC_TIMEOUT);

   logic [2:0]    r_state;
   logic [7:0]    r_fmt;
   logic [2:0]    r_mode;
   logic [2:0]    r_mode_out;
   logic          r_oe_x;
   logic [FW-1:0] r_frames;
   logic [DW-1:0] r_dwell;
   logic [TW-1:0] r_to_cnt;

   logic          w_edge;
   logic          w_timeout;
   logic          w_dwell_done;
   logic          w_settle_abort;
   logic          w_run_abort;

   sync_edge_detect u_vsync_edge (
      .i_clk     (clk_50mhz_in),
      .i_rst_n   (reset_x),
      .i_async_x (vsync_x_in),
      .o_fall    (w_edge)
   );

   assign w_timeout    = (r_to_cnt == TO_MAX);
   assign w_dwell_done = (r_dwell == DWELL_LAST);

   // Losing the request or the signal while still qualifying simply drops back to IDLE
   assign w_settle_abort = !host_enable || (video_format == 8'h00) || w_timeout;

   // Once the mode lines have been driven, any disturbance must pass through MUTE
   assign w_run_abort = !host_enable || (video_format != r_fmt) ||
                        (host_mode != r_mode) || w_timeout;

   // Signal-loss watchdog: clears on every vsync edge, saturates at the timeout value
   always_ff @(posedge clk_50mhz_in) begin
      if (!reset_x) begin
         r_to_cnt <= '0;
      end else if (w_edge) begin
         r_to_cnt <= '0;
      end else if (!w_timeout) begin
         r_to_cnt <= r_to_cnt + TW'(1);
      end
   end

   // Main sequencer: format qualification, mode application, enable and mute dwell.
   // The dwell counter free-runs (saturating) and is cleared by every state transition.
   always_ff @(posedge clk_50mhz_in) begin
      if (!reset_x) begin
         r_state    <= ST_IDLE;
         r_fmt      <= '0;
         r_mode     <= '0;
         r_mode_out <= '0;
         r_oe_x     <= 1'b1;
         r_frames   <= '0;
         r_dwell    <= '0;
      end else begin
         if (r_dwell != DWELL_MAX) begin
            r_dwell <= r_dwell + DW'(1);
         end
         case (r_state)
            ST_IDLE: begin
               r_oe_x <= 1'b1;
               if (host_enable && (video_format != 8'h00)) begin
                  r_fmt    <= video_format;
                  r_frames <= '0;
                  r_dwell  <= '0;
                  r_state  <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (w_settle_abort) begin
                  r_dwell <= '0;
                  r_state <= ST_IDLE;
               end else if (video_format != r_fmt) begin
                  // A format change restarts qualification, even on a vsync clock
                  r_fmt    <= video_format;
                  r_frames <= '0;
               end else if (r_frames == FRAMES_MAX) begin
                  // Mode lines switch here, while output is still disabled
                  r_mode     <= host_mode;
                  r_mode_out <= host_mode;
                  r_dwell    <= '0;
                  r_state    <= ST_APPLY;
               end else if (w_edge) begin
                  // Leaves SETTLE on reaching FRAMES_MAX, so this never wraps
                  r_frames <= r_frames + FW'(1);
               end
            end
            ST_APPLY: begin
               if (w_run_abort) begin
                  r_oe_x  <= 1'b1;
                  r_dwell <= '0;
                  r_state <= ST_MUTE;
               end else if (w_dwell_done) begin
                  r_oe_x  <= 1'b0;
                  r_dwell <= '0;
                  r_state <= ST_ON;
               end
            end
            ST_ON: begin
               if (w_run_abort) begin
                  r_oe_x  <= 1'b1;
                  r_dwell <= '0;
                  r_state <= ST_MUTE;
               end
            end
            ST_MUTE: begin
               r_oe_x <= 1'b1;
               if (w_dwell_done) begin
                  r_dwell <= '0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_oe_x  <= 1'b1;
               r_dwell <= '0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign video_oe_x = r_oe_x;
   assign hd_sd_x    = r_mode_out[MODE_HD_SD_BIT];
   assign rgb_comp_x = r_mode_out[MODE_RGB_COMP_BIT];
   assign int_ext_x  = r_mode_out[MODE_INT_EXT_BIT];
   assign busy       = is_busy(r_state);
   assign state_out  = r_state;

endmodule

// File: tb/tb_video_switch_sequencer.sv
// Scoreboard bench for video_switch_sequencer: expected output transitions are queued by the stimulus,
// a monitor compares every observed output change, its spacing in clocks and the vsync edges between changes.
// No backpressure involved.
module tb_video_switch_sequencer;

   localparam int SF = 4;
   localparam int BC = 16;
   localparam int VT = 1000;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETTLE = 3'd1;
   localparam logic [2:0] S_APPLY  = 3'd2;
   localparam logic [2:0] S_ON     = 3'd3;
   localparam logic [2:0] S_MUTE   = 3'd4;

   logic       clk_50mhz_in = 1'b0;
   logic       reset_x;
   logic       vsync_x_in;
   logic [7:0] video_format;
   logic       host_enable;
   logic [2:0] host_mode;
   logic       video_oe_x;
   logic       hd_sd_x;
   logic       rgb_comp_x;
   logic       int_ext_x;
   logic       busy;
   logic [2:0] state_out;

   always #5 clk_50mhz_in = ~clk_50mhz_in;

   video_switch_sequencer #(
      .SETTLE_FRAMES (SF),
      .BLANK_CYCLES  (BC),
      .VSYNC_TIMEOUT (VT)
   ) dut (
      .clk_50mhz_in (clk_50mhz_in),
      .reset_x      (reset_x),
      .vsync_x_in   (vsync_x_in),
      .video_format (video_format),
      .host_enable  (host_enable),
      .host_mode    (host_mode),
      .video_oe_x   (video_oe_x),
      .hd_sd_x      (hd_sd_x),
      .rgb_comp_x   (rgb_comp_x),
      .int_ext_x    (int_ext_x),
      .busy         (busy),
      .state_out    (state_out)
   );

   typedef struct {
      logic [2:0] st;
      logic [2:0] md;
      int         dt;   // clocks since previous output change, -1 = not checked
      int         ne;   // vsync falls since previous output change, -1 = not checked
      string      nm;
   } exp_t;

   exp_t q[$];
   int   n_chk    = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   vs_falls = 0;
   bit   vs_run   = 1'b0;
   bit   mon_en   = 1'b0;
   bit   rst_seen = 1'b0;

   function automatic void chk(input bit ok, input string nm, input int act, input int req);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, req, req);
   endfunction

   function automatic logic busy_of(input logic [2:0] st);
      return (st == S_SETTLE) || (st == S_APPLY) || (st == S_MUTE);
   endfunction

   function automatic void expect_ev(input logic [2:0] st, input logic [2:0] md,
                                     input int dt, input int ne, input string nm);
      exp_t e;
      e.st = st; e.md = md; e.dt = dt; e.ne = ne; e.nm = nm;
      q.push_back(e);
   endfunction

   // vsync source: 200-clock period, 10 clocks low, driven just after the rising edge
   initial begin
      vsync_x_in = 1'b1;
      forever begin
         @(posedge clk_50mhz_in);
         if (vs_run) begin
            #1 vsync_x_in = 1'b0;
            vs_falls++;
            repeat (10) @(posedge clk_50mhz_in);
            #1 vsync_x_in = 1'b1;
            repeat (189) @(posedge clk_50mhz_in);
         end
      end
   end

   // Monitor: every change of the output vector pops one expected transition
   initial begin : monitor
      logic [7:0] prev, cur, ev;
      int         last_cyc, last_falls;
      bit         started;
      exp_t       e;
      started = 1'b0; prev = '0; last_cyc = 0; last_falls = 0;
      forever begin
         @(negedge clk_50mhz_in);
         cyc++;
         if (mon_en) begin
            cur = {state_out, video_oe_x, hd_sd_x, rgb_comp_x, int_ext_x, busy};
            if (!started) begin
               started = 1'b1; prev = cur; last_cyc = cyc; last_falls = vs_falls;
            end else if (cur != prev) begin
               if ((cur[3:1] != prev[3:1]) && !rst_seen)
                  chk(prev[4] && cur[4] && (cur[7:5] == S_APPLY), "mode_change_only_muted_apply",
                      int'(cur), int'(prev));
               if (q.size() == 0) begin
                  chk(1'b0, "unexpected_output_change", int'(cur), int'(prev));
               end else begin
                  e  = q.pop_front();
                  ev = {e.st, (e.st == S_ON) ? 1'b0 : 1'b1, e.md, busy_of(e.st)};
                  chk(cur == ev, {e.nm, "_outputs"}, int'(cur), int'(ev));
                  if (e.dt >= 0) chk(cyc - last_cyc == e.dt, {e.nm, "_clocks"}, cyc - last_cyc, e.dt);
                  if (e.ne >= 0) chk(vs_falls - last_falls == e.ne, {e.nm, "_vsync_edges"},
                                     vs_falls - last_falls, e.ne);
               end
               prev = cur; last_cyc = cyc; last_falls = vs_falls;
            end
         end
      end
   end

   task automatic wait_state(input logic [2:0] s, input string nm);
      int n = 0;
      while (state_out !== s && n < 3000) begin
         @(negedge clk_50mhz_in);
         n++;
      end
      chk(state_out === s, nm, int'(state_out), int'(s));
   endtask

   // Return about 100 clocks after a vsync fall, i.e. mid-frame
   task automatic wait_mid();
      int f = vs_falls;
      int n = 0;
      while (vs_falls == f && n < 400) begin
         @(negedge clk_50mhz_in);
         n++;
      end
      chk(vs_falls != f, "vsync_running", vs_falls, f + 1);
      repeat (100) @(negedge clk_50mhz_in);
   endtask

   initial begin : stim
      int f0, n;
      reset_x = 1'b0; host_enable = 1'b0; video_format = 8'h00; host_mode = 3'b000;
      repeat (3) @(negedge clk_50mhz_in);
      chk(state_out == S_IDLE, "reset_state", int'(state_out), 0);
      chk(video_oe_x == 1'b1, "reset_oe_x", int'(video_oe_x), 1);
      chk({hd_sd_x, rgb_comp_x, int_ext_x} == 3'b000, "reset_mode_lines",
          int'({hd_sd_x, rgb_comp_x, int_ext_x}), 0);
      chk(busy == 1'b0, "reset_busy", int'(busy), 0);
      reset_x = 1'b1;
      mon_en  = 1'b1;
      vs_run  = 1'b1;

      // Basic bring-up: format 12, mode 101
      wait_mid();
      expect_ev(S_SETTLE, 3'b000, -1, -1, "bringup_settle");
      expect_ev(S_APPLY,  3'b101, -1, SF, "bringup_apply");
      expect_ev(S_ON,     3'b101, BC, 0,  "bringup_on");
      host_enable = 1'b1; video_format = 8'h12; host_mode = 3'b101;
      wait_state(S_ON, "bringup_reach_on");

      // Mode change while on: full mute / requalify cycle
      wait_mid();
      expect_ev(S_MUTE,   3'b101, -1, -1, "modechg_mute");
      expect_ev(S_IDLE,   3'b101, BC, 0,  "modechg_idle");
      expect_ev(S_SETTLE, 3'b101, 1,  0,  "modechg_settle");
      expect_ev(S_APPLY,  3'b010, -1, SF, "modechg_apply");
      expect_ev(S_ON,     3'b010, BC, 0,  "modechg_on");
      host_mode = 3'b010;
      wait_state(S_MUTE, "modechg_reach_mute");
      wait_state(S_ON, "modechg_reach_on");

      // vsync loss while on
      expect_ev(S_MUTE, 3'b010, -1, -1, "timeout_mute");
      expect_ev(S_IDLE, 3'b010, BC, 0,  "timeout_idle");
      f0 = vs_falls; n = 0;
      while (vs_falls == f0 && n < 400) begin @(negedge clk_50mhz_in); n++; end
      vs_run = 1'b0;
      n = 0;
      while (state_out !== S_MUTE && n < 3000) begin @(negedge clk_50mhz_in); n++; end
      // pin fall to MUTE: VSYNC_TIMEOUT plus synchroniser and register latency
      chk(n >= VT && n <= VT + 10, "timeout_latency", n, VT);
      host_enable = 1'b0;
      wait_state(S_IDLE, "timeout_reach_idle");
      vs_run = 1'b1;

      // Format change on the 3rd vsync edge restarts qualification
      wait_mid();
      expect_ev(S_SETTLE, 3'b010, -1, -1, "fmtchg_settle");
      expect_ev(S_APPLY,  3'b101, -1, 3 + SF, "fmtchg_apply");
      expect_ev(S_ON,     3'b101, BC, 0,  "fmtchg_on");
      f0 = vs_falls;
      host_enable = 1'b1; video_format = 8'h12; host_mode = 3'b101;
      n = 0;
      while (vs_falls != f0 + 3 && n < 10000) begin #1; n++; end
      chk(vs_falls == f0 + 3, "fmtchg_third_edge_seen", vs_falls - f0, 3);
      repeat (3) @(posedge clk_50mhz_in);
      #1 video_format = 8'h13;
      wait_state(S_APPLY, "fmtchg_reach_apply");
      wait_state(S_ON, "fmtchg_reach_on");

      // host_enable dropped during APPLY: through MUTE, output never enabled
      wait_mid();
      expect_ev(S_MUTE, 3'b101, -1, -1, "disable_mute");
      expect_ev(S_IDLE, 3'b101, BC, 0,  "disable_idle");
      host_enable = 1'b0;
      wait_state(S_MUTE, "disable_reach_mute");
      wait_state(S_IDLE, "disable_reach_idle");
      host_mode = 3'b011;
      wait_mid();
      expect_ev(S_SETTLE, 3'b101, -1, -1, "applyabort_settle");
      expect_ev(S_APPLY,  3'b011, -1, SF, "applyabort_apply");
      expect_ev(S_MUTE,   3'b011, 5,  0,  "applyabort_mute");
      expect_ev(S_IDLE,   3'b011, BC, 0,  "applyabort_idle");
      host_enable = 1'b1;
      wait_state(S_APPLY, "applyabort_reach_apply");
      repeat (4) @(posedge clk_50mhz_in);
      #1 host_enable = 1'b0;
      wait_state(S_MUTE, "applyabort_reach_mute");
      wait_state(S_IDLE, "applyabort_reach_idle");

      // One-clock reset while on
      wait_mid();
      expect_ev(S_SETTLE, 3'b011, -1, -1, "rst_settle");
      expect_ev(S_APPLY,  3'b011, -1, SF, "rst_apply");
      expect_ev(S_ON,     3'b011, BC, 0,  "rst_on");
      host_enable = 1'b1;
      wait_state(S_ON, "rst_reach_on");
      expect_ev(S_IDLE, 3'b000, -1, -1, "rst_idle");
      @(posedge clk_50mhz_in);
      #1 reset_x = 1'b0; host_enable = 1'b0; rst_seen = 1'b1;
      @(posedge clk_50mhz_in);
      #1 reset_x = 1'b1;
      @(negedge clk_50mhz_in);
      chk(state_out == S_IDLE, "rst_on_state", int'(state_out), 0);
      chk(video_oe_x == 1'b1, "rst_on_oe_x", int'(video_oe_x), 1);
      chk({hd_sd_x, rgb_comp_x, int_ext_x} == 3'b000, "rst_on_mode_lines",
          int'({hd_sd_x, rgb_comp_x, int_ext_x}), 0);
      chk(busy == 1'b0, "rst_on_busy", int'(busy), 0);

      repeat (30) @(negedge clk_50mhz_in);
      chk(q.size() == 0, "scoreboard_drained", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
